// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing control logic: FSM encodings,
// default sizing, and the round-robin priority search used by the arbiter.
package alu_ctrl_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // Default sizing (4 requesters feeding a 4:1 ALU input mux)
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_SEL_W     = 2;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CNT_W     = 4;

    // Widest supported requester count; the search function works at this
    // width so that any legal N_REQ can share one implementation.
    localparam int MAX_REQ   = 8;
    localparam int MAX_SEL_W = 3;

    typedef struct packed {
        logic [MAX_SEL_W-1:0] idx;
        logic                 found;
    } pick_t;

    // Rotate-and-priority-encode: first set bit of req_vec visiting
    // start, start+1, ... modulo n (n must be a power of two <= MAX_REQ).
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]   req_vec,
        input logic [MAX_SEL_W-1:0] start,
        input int                   n
    );
        pick_t                r;
        logic [MAX_SEL_W-1:0] idx;
        logic [MAX_SEL_W-1:0] mask;
        r.idx   = '0;
        r.found = 1'b0;
        mask    = MAX_SEL_W'(n - 1);
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (start + MAX_SEL_W'(k)) & mask;
            if ((k < n) && !r.found && req_vec[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational masked round-robin search: finds the first requester at or
// after ptr (wrapping) whose request is set and which is not excluded.
module rr_priority_pick
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] excl,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    logic [MAX_REQ-1:0] req_pad;
    pick_t              pick;

    // Mask out excluded requesters and pad to the search function's width
    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
            if (gi < N_REQ) begin : g_live
                assign req_pad[gi] = req[gi] & ~excl[gi];
            end else begin : g_dead
                assign req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Run the rotating search over the masked vector
    always_comb begin
        pick   = rr_pick(req_pad, MAX_SEL_W'(ptr), N_REQ);
        winner = SEL_W'(pick.idx);
        found  = pick.found;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU datapath between N_REQ requesters.
// Grants are registered and one-hot; a burst limit forces handoff when the
// owner has held the ALU for MAX_BURST cycles and someone else is waiting.
module alu_rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [CNT_W-1:0] burst_cnt
);

    logic [0:0]       state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             busy_reg, busy_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [N_REQ-1:0] owner_mask;
    logic [SEL_W-1:0] owner_inc;
    logic [SEL_W-1:0] search_ptr;
    logic [N_REQ-1:0] search_excl;
    logic [SEL_W-1:0] win;
    logic             win_found;
    logic             owner_req;
    logic             others_req;
    logic             at_limit;
    logic             grant_en;

    // One-hot of the current owner and one-hot decode of the next winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_decode
            assign owner_mask[gi] = (sel_reg == SEL_W'(gi));
            assign gnt_next[gi]   = grant_en && (win == SEL_W'(gi));
        end
    endgenerate

    assign owner_inc  = sel_reg + SEL_W'(1);
    assign owner_req  = |(req & owner_mask);
    assign others_req = |(req & ~owner_mask);
    assign at_limit   = (cnt_reg == CNT_W'(MAX_BURST));

    // While owned, any new arbitration starts just past the owner and skips it
    assign search_ptr  = (state_reg == ST_OWNED) ? owner_inc : ptr_reg;
    assign search_excl = (state_reg == ST_OWNED) ? owner_mask : '0;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .ptr    (search_ptr),
        .excl   (search_excl),
        .winner (win),
        .found  (win_found)
    );

    // Next-state logic: idle arbitration, release, preemption or hold
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        busy_next  = busy_reg;
        cnt_next   = cnt_reg;
        grant_en   = 1'b0;
        if (state_reg == ST_IDLE) begin
            busy_next = 1'b0;
            if (win_found) begin
                grant_en   = 1'b1;
                sel_next   = win;
                busy_next  = 1'b1;
                cnt_next   = CNT_W'(1);
                state_next = ST_OWNED;
            end
        end else if (!owner_req || (at_limit && others_req)) begin
            // Owner leaves (voluntarily or by preemption): rotate priority
            ptr_next = owner_inc;
            if (win_found) begin
                grant_en  = 1'b1;
                sel_next  = win;
                busy_next = 1'b1;
                cnt_next  = CNT_W'(1);
            end else begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        end else begin
            // Hold: keep the grant, count tenure with saturation
            grant_en = 1'b0;
            busy_next = 1'b1;
            if (!at_limit) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // State and output registers; hold case re-asserts the current grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= (grant_en) ? gnt_next :
                         ((state_reg == ST_OWNED) && (state_next == ST_OWNED)) ? gnt_reg : '0;
            sel_reg   <= sel_next;
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign busy      = busy_reg;
    assign burst_cnt = cnt_reg;

endmodule
